// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared types and constants for the I2C target engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ADDR     = 4'd1,
    ADDR_ACK = 4'd2,
    RX_BYTE  = 4'd3,
    RX_ACK   = 4'd4,
    TX_WAIT  = 4'd5,
    TX_BYTE  = 4'd6,
    TX_ACK   = 4'd7,
    IGNORE   = 4'd8
  } target_state_e;

  localparam logic I2C_RW_READ  = 1'b1;
  localparam logic I2C_RW_WRITE = 1'b0;

  // Address byte matches when its upper seven bits equal the target address;
  // the general-call address (all zeros) is never claimed.
  function automatic logic addr_match(input logic [7:0] addr_byte,
                                      input logic [6:0] target);
    return (addr_byte[7:1] == target) && (addr_byte[7:1] != 7'h00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_bus_sync.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_bus_sync
//  Description : SCL/SDA input synchronizers with SCL edge and START/STOP
//                detection. Synchronizers come out of reset at the idle
//                (high) bus level so no spurious edge is seen on release.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // Fewer than two flops is not a synchronizer; clamp silently.
  localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [STAGES-1:0] scl_sync;
  logic [STAGES-1:0] sda_sync;
  logic              scl_prev;
  logic              sda_prev;

  // Shift pad levels through the synchronizer and keep last synchronized level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[STAGES-2:0], sda_i};
      scl_prev <= scl;
      sda_prev <= sda;
    end
  end

  assign scl       = scl_sync[STAGES-1];
  assign sda       = sda_sync[STAGES-1];
  assign scl_rise  = scl & ~scl_prev;
  assign scl_fall  = ~scl & scl_prev;
  // SCL must be high on both samples so a simultaneous SCL fall is not misread.
  assign start_det = scl & scl_prev & sda_prev & ~sda;
  assign stop_det  = scl & scl_prev & ~sda_prev & sda;

endmodule
`default_nettype wire

// File: rtl/i2c_target.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_target
//  Description : I2C target engine. Matches a 7-bit address, ACKs, delivers
//                written bytes to the fabric and sources read bytes from it,
//                stretching SCL while read data is pending.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_nack,
  output logic       tx_req,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       busy,
  output logic       addr_hit,
  output logic       rw
);

  logic scl, sda, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk       (pclk),
    .rst       (preset),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl       (scl),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  target_state_e state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n;
  logic [7:0] tx_shift, tx_shift_n;
  logic       tx_full, tx_full_n;   // read byte accepted while SCL still high
  logic       ack_drv, ack_drv_n;   // ACK bit currently being driven
  logic       nack_l, nack_l_n;
  logic       sda_oe_n, scl_oe_n, rx_valid_n, tx_req_n, addr_hit_n, rw_n, busy_n;
  logic [7:0] rx_data_n;
  logic [7:0] rx_byte;
  logic [7:0] tx_byte;
  logic       tx_have;

  assign rx_byte = {shift[6:0], sda};
  assign tx_byte = tx_full ? tx_shift : tx_data;
  assign tx_have = tx_full | tx_valid;

  // State register and all registered outputs.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      shift    <= 8'h00;
      tx_shift <= 8'h00;
      tx_full  <= 1'b0;
      ack_drv  <= 1'b0;
      nack_l   <= 1'b0;
      sda_oe   <= 1'b0;
      scl_oe   <= 1'b0;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      addr_hit <= 1'b0;
      rw       <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      tx_shift <= tx_shift_n;
      tx_full  <= tx_full_n;
      ack_drv  <= ack_drv_n;
      nack_l   <= nack_l_n;
      sda_oe   <= sda_oe_n;
      scl_oe   <= scl_oe_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      tx_req   <= tx_req_n;
      addr_hit <= addr_hit_n;
      rw       <= rw_n;
      busy     <= busy_n;
    end
  end

  // Next-state and output decode; bus conditions override bit handling.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    tx_shift_n = tx_shift;
    tx_full_n  = tx_full;
    ack_drv_n  = ack_drv;
    nack_l_n   = nack_l;
    sda_oe_n   = sda_oe;
    scl_oe_n   = scl_oe;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    tx_req_n   = 1'b0;
    addr_hit_n = 1'b0;
    rw_n       = rw;

    if (stop_det) begin
      state_n   = IDLE;
      sda_oe_n  = 1'b0;
      scl_oe_n  = 1'b0;
      tx_full_n = 1'b0;
      ack_drv_n = 1'b0;
    end else if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = 3'd0;
      sda_oe_n  = 1'b0;
      scl_oe_n  = 1'b0;
      tx_full_n = 1'b0;
      ack_drv_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sda_oe_n = 1'b0;
          scl_oe_n = 1'b0;
        end
        ADDR: begin
          if (scl_rise) begin
            shift_n   = rx_byte;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (addr_match(rx_byte, TARGET_ADDR)) begin
                addr_hit_n = 1'b1;
                rw_n       = rx_byte[0];
                ack_drv_n  = 1'b0;
                state_n    = ADDR_ACK;
              end else begin
                state_n = IGNORE;
              end
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!ack_drv) begin
              sda_oe_n  = 1'b1;
              ack_drv_n = 1'b1;
            end else begin
              sda_oe_n  = 1'b0;
              ack_drv_n = 1'b0;
              bit_cnt_n = 3'd0;
              if (rw == I2C_RW_READ) begin
                tx_req_n  = 1'b1;
                tx_full_n = 1'b0;
                state_n   = TX_WAIT;
              end else begin
                state_n = RX_BYTE;
              end
            end
          end
        end
        RX_BYTE: begin
          if (scl_rise) begin
            shift_n   = rx_byte;
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data_n  = rx_byte;
              rx_valid_n = 1'b1;
              nack_l_n   = rx_nack;
              ack_drv_n  = 1'b0;
              state_n    = RX_ACK;
            end
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            if (!ack_drv) begin
              sda_oe_n  = !nack_l;
              ack_drv_n = 1'b1;
            end else begin
              sda_oe_n  = 1'b0;
              ack_drv_n = 1'b0;
              bit_cnt_n = 3'd0;
              state_n   = nack_l ? IGNORE : RX_BYTE;
            end
          end
        end
        TX_WAIT: begin
          if (tx_valid && !tx_full) begin
            tx_shift_n = tx_data;
            tx_full_n  = 1'b1;
          end
          // First bit may only be placed while SCL is low.
          if (tx_have && !scl) begin
            tx_shift_n = tx_byte;
            tx_full_n  = 1'b0;
            sda_oe_n   = !tx_byte[7];
            scl_oe_n   = 1'b0;
            bit_cnt_n  = 3'd0;
            state_n    = TX_BYTE;
          end else begin
            scl_oe_n = !tx_have && !scl;
          end
        end
        TX_BYTE: begin
          if (scl_fall) begin
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              sda_oe_n = 1'b0;
              state_n  = TX_ACK;
            end else begin
              tx_shift_n = {tx_shift[6:0], 1'b0};
              sda_oe_n   = !tx_shift[6];
            end
          end
        end
        TX_ACK: begin
          if (scl_rise) begin
            if (!sda) begin
              tx_req_n  = 1'b1;
              tx_full_n = 1'b0;
              state_n   = TX_WAIT;
            end else begin
              state_n = IGNORE;
            end
          end
        end
        IGNORE: begin
          sda_oe_n = 1'b0;
          scl_oe_n = 1'b0;
        end
        default: begin
          state_n  = IDLE;
          sda_oe_n = 1'b0;
          scl_oe_n = 1'b0;
        end
      endcase
    end

    busy_n = (state_n != IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_i2c_target.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_target
//  Description : Self-checking bench for i2c_target with a bus controller
//                model, fabric responders and a transaction-level reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_target;

  localparam int Q      = 10;   // quarter SCL period in pclk cycles
  localparam int HALF   = 2 * Q;
  localparam int BOUND  = 2000;

  logic       pclk;
  logic       preset;
  logic       m_scl_low, m_sda_low;
  logic       scl_w, sda_w;
  logic       scl_oe, sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid, rx_nack, tx_req, tx_valid, busy, addr_hit, rw;
  logic [7:0] tx_data;

  assign scl_w = !(m_scl_low | scl_oe);
  assign sda_w = !(m_sda_low | sda_oe);

  i2c_target #(.TARGET_ADDR(7'h50), .SYNC_STAGES(2)) dut (
    .pclk     (pclk),
    .preset   (preset),
    .scl_i    (scl_w),
    .sda_i    (sda_w),
    .scl_oe   (scl_oe),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_nack  (rx_nack),
    .tx_req   (tx_req),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .busy     (busy),
    .addr_hit (addr_hit),
    .rw       (rw)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Fabric-side monitor: log delivered bytes and count pulses.
  int         rx_cnt = 0, hit_cnt = 0, req_cnt = 0;
  logic [7:0] rx_log [256];
  logic       rw_log [256];
  always @(negedge pclk) begin
    if (rx_valid) begin rx_log[rx_cnt % 256] = rx_data; rx_cnt++; end
    if (addr_hit) begin rw_log[hit_cnt % 256] = rw; hit_cnt++; end
    if (tx_req) req_cnt++;
  end

  // Fabric-side read responder: answers each tx_req after tx_delay cycles.
  logic [7:0] tx_src [256];
  int         tx_rd = 0;
  int         tx_delay = 0;
  initial begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    forever begin
      @(posedge pclk); #1;
      if (tx_req) begin
        repeat (tx_delay) @(posedge pclk);
        #1;
        tx_data  = tx_src[tx_rd % 256];
        tx_rd++;
        tx_valid = 1'b1;
        @(posedge pclk); #1;
        tx_valid = 1'b0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- controller bus model ----------------
  int max_stretch;

  task automatic wait_n(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic release_scl();
    int s = 0;
    m_scl_low = 1'b0;
    while (!scl_w && s < BOUND) begin @(negedge pclk); s++; end
    if (s >= BOUND) check("scl_release_timeout", {31'd0, scl_w}, 32'd1);
    if (s > max_stretch) max_stretch = s;
  endtask

  task automatic do_bit(input logic b, output logic rb);
    wait_n(Q);
    m_sda_low = !b;
    wait_n(Q);
    release_scl();
    wait_n(Q);
    rb = sda_w;
    wait_n(Q);
    m_scl_low = 1'b1;
  endtask

  task automatic start_cond();
    if (m_scl_low) begin
      wait_n(Q);
      m_sda_low = 1'b0;
      wait_n(Q);
      release_scl();
      wait_n(HALF);
    end
    m_sda_low = 1'b1;
    wait_n(HALF);
    m_scl_low = 1'b1;
  endtask

  task automatic stop_cond();
    wait_n(Q);
    m_sda_low = 1'b1;
    wait_n(Q);
    release_scl();
    wait_n(HALF);
    m_sda_low = 1'b0;
    wait_n(HALF);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic rb;
    for (int i = 7; i >= 0; i--) do_bit(d[i], rb);
    do_bit(1'b1, rb);
    ack = !rb;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic rb;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      do_bit(1'b1, rb);
      d = {d[6:0], rb};
    end
    do_bit(!ack, rb);
  endtask

  // ---------------- tests ----------------
  initial begin
    logic       ack;
    logic [7:0] d;
    int         rx0, hit0, req0, rd0;

    preset    = 1'b1;
    m_scl_low = 1'b0;
    m_sda_low = 1'b0;
    rx_nack   = 1'b0;
    wait_n(5);
    check("reset_sda_oe",   {31'd0, sda_oe},   32'd0);
    check("reset_scl_oe",   {31'd0, scl_oe},   32'd0);
    check("reset_busy",     {31'd0, busy},     32'd0);
    check("reset_outs",     {24'd0, rx_valid, tx_req, addr_hit, rw, 4'd0}, 32'd0);
    check("reset_rx_data",  {24'd0, rx_data},  32'd0);
    preset = 1'b0;
    wait_n(5);

    // Write 0xA5, 0x3C to 0x50.
    rx0 = rx_cnt; hit0 = hit_cnt;
    start_cond();
    write_byte(8'hA0, ack); check("t1_addr_ack", {31'd0, ack}, 32'd1);
    write_byte(8'hA5, ack); check("t1_d0_ack",   {31'd0, ack}, 32'd1);
    write_byte(8'h3C, ack); check("t1_d1_ack",   {31'd0, ack}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    stop_cond();
    wait_n(5);
    check("t1_rx_count", rx_cnt - rx0, 32'd2);
    check("t1_rx0", {24'd0, rx_log[rx0 % 256]}, 32'hA5);
    check("t1_rx1", {24'd0, rx_log[(rx0 + 1) % 256]}, 32'h3C);
    check("t1_hits", hit_cnt - hit0, 32'd1);
    check("t1_busy_after_stop", {31'd0, busy}, 32'd0);

    // Address 0x51: ignored until STOP.
    rx0 = rx_cnt; hit0 = hit_cnt;
    start_cond();
    write_byte(8'hA2, ack); check("t2_addr_nack", {31'd0, ack}, 32'd0);
    write_byte(8'h77, ack); check("t2_data_nack", {31'd0, ack}, 32'd0);
    check("t2_busy_ignore", {31'd0, busy}, 32'd1);
    stop_cond();
    wait_n(5);
    check("t2_no_hit", hit_cnt - hit0, 32'd0);
    check("t2_no_rx",  rx_cnt - rx0,   32'd0);
    check("t2_busy_after_stop", {31'd0, busy}, 32'd0);

    // Read 0xC3 with 50-cycle fabric latency; controller NACKs.
    req0 = req_cnt;
    tx_src[tx_rd % 256] = 8'hC3;
    tx_delay = 50;
    start_cond();
    write_byte(8'hA1, ack); check("t3_addr_ack", {31'd0, ack}, 32'd1);
    max_stretch = 0;
    read_byte(d, 1'b0);
    check("t3_data", {24'd0, d}, 32'hC3);
    check("t3_low_time_ok", {31'd0, (HALF + max_stretch >= 44) && (HALF + max_stretch <= 66)}, 32'd1);
    wait_n(5);
    check("t3_sda_released", {31'd0, sda_oe}, 32'd0);
    stop_cond();
    wait_n(5);
    check("t3_tx_req_once", req_cnt - req0, 32'd1);
    tx_delay = 0;

    // Write with rx_nack=1: byte NACKed, following byte not captured.
    rx0 = rx_cnt;
    start_cond();
    write_byte(8'hA0, ack); check("t4_addr_ack", {31'd0, ack}, 32'd1);
    rx_nack = 1'b1;
    write_byte(8'h11, ack); check("t4_d0_nack", {31'd0, ack}, 32'd0);
    rx_nack = 1'b0;
    write_byte(8'h22, ack); check("t4_d1_nack", {31'd0, ack}, 32'd0);
    stop_cond();
    wait_n(5);
    check("t4_rx_count", rx_cnt - rx0, 32'd1);
    check("t4_rx0", {24'd0, rx_log[rx0 % 256]}, 32'h11);

    // Write 0x01, repeated START, read 0x7E (ACK), 0x7F (NACK).
    rx0 = rx_cnt; hit0 = hit_cnt; req0 = req_cnt;
    tx_src[tx_rd % 256]       = 8'h7E;
    tx_src[(tx_rd + 1) % 256] = 8'h7F;
    start_cond();
    write_byte(8'hA0, ack); check("t5_waddr_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h01, ack); check("t5_wdata_ack", {31'd0, ack}, 32'd1);
    start_cond();
    write_byte(8'hA1, ack); check("t5_raddr_ack", {31'd0, ack}, 32'd1);
    read_byte(d, 1'b1); check("t5_rd0", {24'd0, d}, 32'h7E);
    read_byte(d, 1'b0); check("t5_rd1", {24'd0, d}, 32'h7F);
    stop_cond();
    wait_n(5);
    check("t5_rx0", {24'd0, rx_log[rx0 % 256]}, 32'h01);
    check("t5_hits", hit_cnt - hit0, 32'd2);
    check("t5_rw_first",  {31'd0, rw_log[hit0 % 256]}, 32'd0);
    check("t5_rw_second", {31'd0, rw_log[(hit0 + 1) % 256]}, 32'd1);
    check("t5_tx_req", req_cnt - req0, 32'd2);

    // Reset asserted mid-read while the target drives SDA low.
    tx_src[tx_rd % 256] = 8'h00;
    start_cond();
    write_byte(8'hA1, ack); check("t6_addr_ack", {31'd0, ack}, 32'd1);
    wait_n(Q);
    check("t6_sda_driving", {31'd0, sda_oe}, 32'd1);
    preset = 1'b1;
    #1;
    check("t6_async_sda", {31'd0, sda_oe}, 32'd0);
    check("t6_async_scl", {31'd0, scl_oe}, 32'd0);
    m_scl_low = 1'b0;
    wait_n(2);
    m_sda_low = 1'b0;
    wait_n(5);
    preset = 1'b0;
    wait_n(20);
    check("t6_idle_busy", {31'd0, busy}, 32'd0);
    rx0 = rx_cnt;
    start_cond();
    write_byte(8'hA0, ack); check("t6_post_addr_ack", {31'd0, ack}, 32'd1);
    write_byte(8'h5A, ack); check("t6_post_data_ack", {31'd0, ack}, 32'd1);
    stop_cond();
    wait_n(5);
    check("t6_post_rx_count", rx_cnt - rx0, 32'd1);
    check("t6_post_rx0", {24'd0, rx_log[rx0 % 256]}, 32'h5A);

    // Randomized transactions against a transaction-level reference.
    for (int t = 0; t < 12; t++) begin
      logic [6:0] addr;
      logic       rd, matched, alive, nk, exp_ack;
      int         nbytes, n_exp;
      logic [7:0] exp_rx [4];
      logic [7:0] src [4];

      addr   = ($urandom_range(0, 9) < 7) ? 7'h50 : 7'($urandom_range(0, 127));
      rd     = 1'($urandom_range(0, 1));
      nbytes = $urandom_range(1, 4);
      matched = (addr == 7'h50);
      rx0 = rx_cnt; hit0 = hit_cnt; req0 = req_cnt;
      n_exp = 0;

      start_cond();
      write_byte({addr, rd}, ack);
      check($sformatf("r%0d_addr_ack", t), {31'd0, ack}, {31'd0, matched});

      if (!rd) begin
        alive = matched;
        for (int i = 0; i < nbytes; i++) begin
          d  = 8'($urandom);
          nk = ($urandom_range(0, 3) == 0);
          rx_nack = nk;
          write_byte(d, ack);
          exp_ack = alive && !nk;
          check($sformatf("r%0d_w%0d_ack", t, i), {31'd0, ack}, {31'd0, exp_ack});
          if (alive) begin exp_rx[n_exp] = d; n_exp++; end
          if (nk) alive = 1'b0;
        end
        rx_nack = 1'b0;
        stop_cond();
        wait_n(5);
        check($sformatf("r%0d_rx_count", t), rx_cnt - rx0, n_exp);
        for (int i = 0; i < n_exp; i++)
          check($sformatf("r%0d_rx%0d", t, i), {24'd0, rx_log[(rx0 + i) % 256]}, {24'd0, exp_rx[i]});
      end else begin
        rd0 = tx_rd;
        tx_delay = $urandom_range(0, 30);
        for (int i = 0; i < 4; i++) begin
          src[i] = 8'($urandom);
          tx_src[(rd0 + i) % 256] = src[i];
        end
        for (int i = 0; i < nbytes; i++) begin
          read_byte(d, i != nbytes - 1);
          check($sformatf("r%0d_rd%0d", t, i), {24'd0, d}, matched ? {24'd0, src[i]} : 32'hFF);
        end
        stop_cond();
        wait_n(40);
        check($sformatf("r%0d_tx_req", t), req_cnt - req0, matched ? nbytes : 0);
        tx_delay = 0;
      end
      check($sformatf("r%0d_hits", t), hit_cnt - hit0, {31'd0, matched});
      check($sformatf("r%0d_busy", t), {31'd0, busy}, 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) engine: the responder end of the bus driven by i2c_core.
- Samples open-drain SCL/SDA, detects START/STOP and repeated START, matches a 7-bit address, and ACKs.
- Delivers written bytes to the fabric and sources read bytes from it, stretching SCL while the fabric prepares read data.
- Used as the bus-functional target behind i2c_tb_top and as a synthesizable target IP.

Parameters:
- TARGET_ADDR, 7'h50, 7-bit address this target answers to.
- SYNC_STAGES, 2, flops in each SCL/SDA input synchronizer (minimum 2).

Ports:
- pclk  input  1  system clock; all logic on rising edge.
- preset  input  1  asynchronous, active-high reset.
- scl_i  input  1  SCL pad level.
- sda_i  input  1  SDA pad level.
- scl_oe  output  1  1 = pull SCL low (stretch).
- sda_oe  output  1  1 = pull SDA low.
- rx_data  output  8  last byte written by the controller.
- rx_valid  output  1  one-cycle pulse when rx_data updates.
- rx_nack  input  1  sampled at ACK time of a write data byte; 1 = respond NACK.
- tx_req  output  1  one-cycle pulse requesting the next read byte.
- tx_data  input  8  read byte; captured when tx_valid=1 while waiting.
- tx_valid  input  1  tx_data qualifier.
- busy  output  1  1 between START and STOP, inclusive of the START/STOP cycles.
- addr_hit  output  1  one-cycle pulse on address match; rw is valid in the same cycle.
- rw  output  1  R/W bit of the last matched address (1 = read).

Behaviour:
- Reset is asynchronous and active-high. While preset=1, all outputs are 0, state=IDLE, and the synchronizers are preset to 1.
- Edges come from synchronized levels:
  - scl_rise/scl_fall: synchronized SCL changes between consecutive cycles.
  - START: synchronized SDA 1->0 while SCL=1.
  - STOP: synchronized SDA 0->1 while SCL=1.
- Bit timing:
  - Data bits are sampled on the cycle scl_rise is detected.
  - sda_oe changes only on the cycle after scl_fall is detected.
- Bit counter: 3 bits, MSB first; a byte is complete after 8 scl_rise events.
- States and transitions:
  - IDLE: wait for START -> ADDR.
  - ADDR: shift 8 bits.
    - byte[7:1]==TARGET_ADDR -> pulse addr_hit, latch rw=byte[0], go to ADDR_ACK.
    - Otherwise -> IGNORE.
  - ADDR_ACK: after scl_fall, sda_oe=1 for one SCL period; released on the next scl_fall.
    - rw=0 -> RX_BYTE.
    - rw=1 -> pulse tx_req, go to TX_WAIT.
  - RX_BYTE: shift 8 bits, then load rx_data, pulse rx_valid (same cycle as 8th scl_rise), latch rx_nack, go to RX_ACK.
  - RX_ACK: sda_oe = !latched rx_nack for the ACK bit, then -> RX_BYTE.
    - NACK -> IGNORE.
  - TX_WAIT: scl_oe=1 from the cycle after entry, held while SCL is low, until tx_valid=1.
    - tx_valid=1: capture tx_data, release scl_oe the same cycle, go to TX_BYTE.
    - If tx_valid is already 1 on the entry cycle, no stretch occurs.
  - TX_BYTE: drive sda_oe = !bit (MSB first), changing after each scl_fall. After the 8th bit's scl_fall, release SDA and go to TX_ACK.
  - TX_ACK: sample SDA on scl_rise.
    - 0 (ACK) -> pulse tx_req, go to TX_WAIT.
    - 1 (NACK) -> IGNORE.
  - IGNORE: both lines released; wait for START or STOP.
- STOP in any state -> IDLE; all oe outputs drop to 0 the next cycle.
- START in any state (repeated START) -> ADDR, bit counter cleared, sda_oe/scl_oe released.
- START/STOP detection takes priority over bit sampling in the same cycle.
- A STOP or START during TX_WAIT aborts the stretch. A tx_valid arriving afterwards is ignored.
- rx_nack and tx_valid are don't-care outside the ACK and TX_WAIT windows.
- General call (address 0) is not matched.
- Reset mid-transfer releases both lines immediately, asynchronously.

Decomposition:
- i2c_pkg:
  - target_state_e enum (IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_WAIT, TX_BYTE, TX_ACK, IGNORE).
  - I2C_RW_READ / I2C_RW_WRITE constants.
- Sub-module i2c_bus_sync: per-line synchronizer plus edge and START/STOP detection, shared with i2c_core.

Test Plan:
- Write to 0x50, data 0xA5, 0x3C, then STOP:
  - Address and both bytes ACKed.
  - rx_valid pulses twice, with rx_data 0xA5 then 0x3C.
  - busy returns to 0 after STOP.
- Address 0x51 write:
  - No ACK (SDA stays high on bit 9).
  - No addr_hit.
  - Target stays in IGNORE until STOP.
- Read from 0x50, tx_valid delayed 50 cycles after tx_req, tx_data 0xC3, controller NACKs:
  - SCL held low for about 50 cycles.
  - Bus shows 0xC3.
  - One tx_req only; SDA released after NACK.
- Write 0x50, byte 0x11 with rx_nack=1:
  - Byte 0x11 is NACKed.
  - A following byte is not captured (no rx_valid).
- Write 0x50, byte 0x01, repeated START, read 0x50 with tx_data 0x7E, 0x7F, ACK then NACK:
  - rw toggles 0 -> 1.
  - Bus shows 0x7E, 0x7F.
  - tx_req pulses twice.
- preset asserted mid-read while sda_oe=1:
  - sda_oe and scl_oe go to 0 asynchronously.
  - State is IDLE after release.
  - Next START is handled normally.
